// File: rtl/hdc_pkg.sv
//------------------------------------------------------------------------------
// hdc_pkg
//------------------------------------------------------------------------------
// Shared definitions for the HDC classification path: scheduler state
// encoding, classifier label codes and the message geometry defaults used by
// the encoder, the scheduler and the top-level main block.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hdc_pkg;

   localparam int HDC_MAX_LENGTH = 160;
   localparam int HDC_CHAR_W     = 8;

   localparam logic [1:0] LBL_NONE = 2'b00;
   localparam logic [1:0] LBL_HAM  = 2'b01;
   localparam logic [1:0] LBL_SPAM = 2'b10;
   localparam logic [1:0] LBL_ERR  = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      STREAM   = 3'd1,
      CLASSIFY = 3'd2,
      WAIT     = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Only HAM and SPAM are meaningful classifier answers.
   function automatic logic label_ok(input logic [1:0] lbl);
      return (lbl == LBL_HAM) || (lbl == LBL_SPAM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hdc_classify_scheduler_if.sv
//------------------------------------------------------------------------------
// hdc_classify_scheduler_if
//------------------------------------------------------------------------------
// Bundles the three scheduler handshakes: message request (in_*, msg,
// length), encoder stream (enc_*), classifier trigger/response (cls_*) plus
// the result/status outputs.
//   modport slave  : the scheduler itself
//   modport master : the surrounding environment (buffer, encoder, AM)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hdc_classify_scheduler_if
   import hdc_pkg::*;
#(
   parameter int MAX_LENGTH = HDC_MAX_LENGTH,
   parameter int CHAR_W     = HDC_CHAR_W,
   parameter int LEN_W      = 8
) ();

   logic                         in_valid;
   logic                         in_ready;
   logic [MAX_LENGTH*CHAR_W-1:0] msg;
   logic [LEN_W-1:0]             length;
   logic                         enc_valid;
   logic                         enc_ready;
   logic [CHAR_W-1:0]            enc_char;
   logic                         enc_first;
   logic                         enc_last;
   logic                         cls_start;
   logic                         cls_done;
   logic [1:0]                   cls_label;
   logic [1:0]                   result;
   logic                         result_valid;
   logic                         busy;

   modport slave (
      input  in_valid, msg, length, enc_ready, cls_done, cls_label,
      output in_ready, enc_valid, enc_char, enc_first, enc_last,
             cls_start, result, result_valid, busy
   );

   modport master (
      output in_valid, msg, length, enc_ready, cls_done, cls_label,
      input  in_ready, enc_valid, enc_char, enc_first, enc_last,
             cls_start, result, result_valid, busy
   );

endinterface

`default_nettype wire

// File: rtl/hdc_char_mux.sv
//------------------------------------------------------------------------------
// hdc_char_mux
//------------------------------------------------------------------------------
// Selects one CHAR_W-wide slot out of the registered message word.
// Ports:
//   msg  in  MAX_LENGTH*CHAR_W  registered message, slot 0 least significant
//   slot in  LEN_W              slot number to select
//   ch   out CHAR_W             selected character (0 when slot is out of range)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hdc_char_mux #(
   parameter int MAX_LENGTH = 160,
   parameter int CHAR_W     = 8,
   parameter int LEN_W      = 8
) (
   input  wire  [MAX_LENGTH*CHAR_W-1:0] msg,
   input  wire  [LEN_W-1:0]             slot,
   output logic [CHAR_W-1:0]            ch
);

   // Explicit compare-per-slot avoids a variable part-select whose index
   // width would have to track MAX_LENGTH.
   always_comb begin
      ch = '0;
      for (int k = 0; k < MAX_LENGTH; k++) begin
         if (slot == LEN_W'(k)) begin
            ch = msg[k*CHAR_W +: CHAR_W];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hdc_classify_scheduler.sv
//------------------------------------------------------------------------------
// hdc_classify_scheduler
//------------------------------------------------------------------------------
// Sequencer between the message buffer and the HDC datapath: latches one
// message, streams its characters (char 0 first) into the n-gram encoder,
// pulses the associative-memory classifier and holds the 2-bit result.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of hdc_classify_scheduler_if
// Optional build macro: HDC_SCHED_TIMEOUT_EN - classifier watchdog of
//   TIMEOUT cycles in WAIT; on expiry the result is 11 (error).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hdc_classify_scheduler
   import hdc_pkg::*;
#(
   parameter int MAX_LENGTH = HDC_MAX_LENGTH,
   parameter int CHAR_W     = HDC_CHAR_W,
   parameter int LEN_W      = 8,
   parameter int TIMEOUT    = 1024
) (
   input wire clk,
   input wire reset,
   hdc_classify_scheduler_if.slave bus
);

   localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LENGTH);
   localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

   if ((2**LEN_W) <= MAX_LENGTH || TIMEOUT < 1) begin : g_bad_params
      $error("hdc_classify_scheduler: need 2**LEN_W > MAX_LENGTH and TIMEOUT >= 1");
   end

   state_t                       r_state;
   logic [MAX_LENGTH*CHAR_W-1:0] r_msg;
   logic [LEN_W-1:0]             r_length;
   logic [LEN_W-1:0]             r_index;
   logic                         r_in_ready;
   logic                         r_enc_valid;
   logic                         r_cls_start;
   logic                         r_result_valid;
   logic                         r_busy;
   logic [1:0]                   r_result;

   logic [LEN_W-1:0]             w_slot;
   logic [CHAR_W-1:0]            w_char;
   logic                         w_hs;
   logic                         w_last;

`ifdef HDC_SCHED_TIMEOUT_EN
   localparam int               c_tmo_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
   logic [c_tmo_w-1:0]          r_wait_cnt;
`endif

   // The string is right-aligned: char i lives in slot (length-1-i).
   assign w_slot = r_length - r_index - c_one;

   hdc_char_mux #(
      .MAX_LENGTH (MAX_LENGTH),
      .CHAR_W     (CHAR_W),
      .LEN_W      (LEN_W)
   ) u_char_mux (
      .msg  (r_msg),
      .slot (w_slot),
      .ch   (w_char)
   );

   assign w_hs   = r_enc_valid & bus.enc_ready;
   assign w_last = (r_index == (r_length - c_one));

   // Stream outputs depend only on registered index/copy, so they hold
   // stable for as long as enc_ready stays low.
   assign bus.enc_valid    = r_enc_valid;
   assign bus.enc_char     = r_enc_valid ? w_char : '0;
   assign bus.enc_first    = r_enc_valid & (r_index == '0);
   assign bus.enc_last     = r_enc_valid & w_last;
   assign bus.in_ready     = r_in_ready;
   assign bus.cls_start    = r_cls_start;
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.busy         = r_busy;

   // Output flags are set on the transition into the state that owns them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_msg          <= '0;
         r_length       <= '0;
         r_index        <= '0;
         r_in_ready     <= 1'b1;
         r_enc_valid    <= 1'b0;
         r_cls_start    <= 1'b0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_result       <= LBL_NONE;
`ifdef HDC_SCHED_TIMEOUT_EN
         r_wait_cnt     <= '0;
`endif
      end else begin
         r_cls_start    <= 1'b0;
         r_result_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_msg      <= bus.msg;
                  r_length   <= bus.length;
                  r_index    <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (bus.length == '0 || bus.length > c_max_len) begin
                     r_result       <= LBL_ERR;
                     r_result_valid <= 1'b1;
                     r_state        <= DONE;
                  end else begin
                     r_enc_valid <= 1'b1;
                     r_state     <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (w_hs) begin
                  r_index <= r_index + c_one;
                  if (w_last) begin
                     r_enc_valid <= 1'b0;
                     r_cls_start <= 1'b1;
                     r_state     <= CLASSIFY;
                  end
               end
            end
            CLASSIFY: begin
`ifdef HDC_SCHED_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
               r_state <= WAIT;
            end
            WAIT: begin
               if (bus.cls_done) begin
                  r_result       <= label_ok(bus.cls_label) ? bus.cls_label : LBL_ERR;
                  r_result_valid <= 1'b1;
                  r_state        <= DONE;
               end
`ifdef HDC_SCHED_TIMEOUT_EN
               else if (r_wait_cnt == c_tmo_last) begin
                  r_result       <= LBL_ERR;
                  r_result_valid <= 1'b1;
                  r_state        <= DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_tmo_one;
               end
`endif
            end
            DONE: begin
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hdc_classify_scheduler.sv
//------------------------------------------------------------------------------
// tb_hdc_classify_scheduler
//------------------------------------------------------------------------------
// Scoreboard bench for hdc_classify_scheduler. Messages are built as byte
// strings; the expected beat list and result are derived from the string and
// the chosen classifier label, and a negedge monitor pops and compares.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_hdc_classify_scheduler;

   localparam int ML = 160;
   localparam int CW = 8;
   localparam int LW = 8;
`ifdef HDC_SCHED_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hdc_classify_scheduler_if #(.MAX_LENGTH(ML), .CHAR_W(CW), .LEN_W(LW)) bus ();

   hdc_classify_scheduler #(
      .MAX_LENGTH (ML),
      .CHAR_W     (CW),
      .LEN_W      (LW),
      .TIMEOUT    (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [CW-1:0] ch;
      logic          first;
      logic          last;
   } beat_t;

   beat_t        exp_beats[$];
   logic [1:0]   exp_res[$];
   int           cls_dly_q[$];
   logic [1:0]   cls_lbl_q[$];
   int           hs_cyc[$];
   byte unsigned txt[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int cls_cnt = 0;
   int cls_cyc = 0;
   int res_cyc = 0;
   int n_res = 0;
   int rmode = 0;
   int pat_i = 0;
   bit prev_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},     32'(bus.in_ready),     32'd1);
      chk({tag, "_enc_valid"},    32'(bus.enc_valid),    32'd0);
      chk({tag, "_enc_first"},    32'(bus.enc_first),    32'd0);
      chk({tag, "_enc_last"},     32'(bus.enc_last),     32'd0);
      chk({tag, "_enc_char"},     32'(bus.enc_char),     32'd0);
      chk({tag, "_cls_start"},    32'(bus.cls_start),    32'd0);
      chk({tag, "_result"},       32'(bus.result),       32'd0);
      chk({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_busy"},         32'(bus.busy),         32'd0);
   endtask

   always @(posedge clk) cyc++;

   // Monitor: compares every presented beat against the front of the
   // scoreboard; a beat is only consumed on a handshake.
   always @(negedge clk) begin
      if (!reset) begin
         prev_pend = 1'b0;
      end else begin
         if (prev_pend) chk("valid_held", 32'(bus.enc_valid), 32'd1);
         if (bus.enc_valid) begin
            if (exp_beats.size() == 0) begin
               flag("unexpected_beat");
            end else begin
               chk("enc_char",  32'(bus.enc_char),  32'(exp_beats[0].ch));
               chk("enc_first", 32'(bus.enc_first), 32'(exp_beats[0].first));
               chk("enc_last",  32'(bus.enc_last),  32'(exp_beats[0].last));
               if (bus.enc_ready) begin
                  void'(exp_beats.pop_front());
                  hs_cyc.push_back(cyc);
               end
            end
         end
         prev_pend = bus.enc_valid && !bus.enc_ready;
         if (bus.cls_start) begin
            cls_cnt++;
            cls_cyc = cyc;
         end
         if (bus.result_valid) begin
            if (exp_res.size() == 0) flag("unexpected_result");
            else chk("result", 32'(bus.result), 32'(exp_res.pop_front()));
            res_cyc = cyc;
            n_res++;
         end
      end
   end

   // Encoder back-pressure: 0 = always ready, 1 = random, 2 = 1,0,0,1 pattern.
   initial begin
      bus.enc_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1:       bus.enc_ready = 1'($urandom_range(0, 1));
            2: begin
               bus.enc_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
               pat_i++;
            end
            default: bus.enc_ready = 1'b1;
         endcase
      end
   end

   // Classifier model: answers each cls_start after the queued delay
   // (delay 0 = never answers).
   initial begin
      int d;
      logic [1:0] l;
      bus.cls_done  = 1'b0;
      bus.cls_label = 2'b00;
      forever begin
         @(negedge clk);
         if (reset && bus.cls_start) begin
            if (cls_dly_q.size() == 0) begin
               flag("unexpected_cls_start");
            end else begin
               d = cls_dly_q.pop_front();
               l = cls_lbl_q.pop_front();
               if (d > 0) begin
                  repeat (d) @(posedge clk);
                  #1;
                  bus.cls_done  = 1'b1;
                  bus.cls_label = l;
                  @(posedge clk);
                  #1;
                  bus.cls_done  = 1'b0;
                  bus.cls_label = 2'($urandom);
               end
            end
         end
      end
   end

   task automatic send(input int len, input int lbl, input int dly, input bit wait_res,
                       output int acc);
      logic [ML*CW-1:0] m;
      bit bad;
      bit ok;
      int n0;
      int c0;
      m   = '0;
      bad = (len == 0) || (len > ML);
      if (bad) begin
         for (int w = 0; w < (ML*CW)/32; w++) m[w*32 +: 32] = $urandom;
         exp_res.push_back(2'b11);
      end else begin
         for (int i = 0; i < len; i++) begin
            m = (m << CW) | (ML*CW)'(txt[i]);
            exp_beats.push_back('{ch: txt[i], first: (i == 0), last: (i == len - 1)});
         end
         cls_dly_q.push_back(dly);
         cls_lbl_q.push_back(2'(lbl));
         if (dly > 0) exp_res.push_back((lbl == 1 || lbl == 2) ? 2'(lbl) : 2'b11);
`ifdef HDC_SCHED_TIMEOUT_EN
         else exp_res.push_back(2'b11);
`endif
      end
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) flag("in_ready_timeout");
      n0 = n_res;
      c0 = cls_cnt;
      hs_cyc.delete();
      bus.in_valid  = 1'b1;
      bus.msg       = m;
      bus.length    = LW'(len);
      // A stray cls_done while idle must be ignored.
      bus.cls_done  = 1'b1;
      bus.cls_label = 2'b11;
      @(posedge clk);
      #1;
      acc           = cyc;
      bus.in_valid  = 1'b0;
      bus.msg       = ~m;
      bus.length    = LW'($urandom);
      bus.cls_done  = 1'b0;
      if (wait_res) begin
         ok = 1'b0;
         for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (n_res > n0) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) flag("result_timeout");
         chk("beats_left", 32'(exp_beats.size()), 32'd0);
         chk("cls_start_count", 32'(cls_cnt - c0), bad ? 32'd0 : 32'd1);
      end
   endtask

   task automatic fill_txt(input int len);
      txt.delete();
      for (int i = 0; i < len; i++) txt.push_back(8'($urandom));
   endtask

   task automatic abort_reset();
      reset = 1'b0;
      exp_beats.delete();
      exp_res.delete();
      cls_dly_q.delete();
      cls_lbl_q.delete();
   endtask

   initial begin
      int acc;
      int c0;
      int n0;
      int len;
      int hi;
      bus.in_valid = 1'b0;
      bus.msg      = '0;
      bus.length   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      @(posedge clk);
      #1 reset = 1'b1;

      // "abc", label SPAM, answer 2 cycles after cls_start
      rmode = 0;
      txt   = '{8'h61, 8'h62, 8'h63};
      send(3, 2, 2, 1'b1, acc);
      chk("abc_beats", 32'(hs_cyc.size()), 32'd3);
      if (hs_cyc.size() == 3) begin
         chk("abc_first_lat", 32'(hs_cyc[0]), 32'(acc));
         chk("abc_back2back", 32'(hs_cyc[2]), 32'(acc + 2));
      end
      chk("abc_wait_lat", 32'(res_cyc - cls_cyc), 32'd3);
      @(negedge clk);
      chk("abc_rv_pulse", 32'(bus.result_valid), 32'd0);
      chk("abc_hold", 32'(bus.result), 32'd2);

      // Length 5 under 1,0,0,1 back-pressure
      rmode = 2;
      pat_i = 0;
      fill_txt(5);
      send(5, 1, 3, 1'b1, acc);
      chk("bp_handshakes", 32'(hs_cyc.size()), 32'd5);
      rmode = 0;

      // Illegal lengths
      foreach (txt[i]) txt[i] = 8'h00;
      send(0, 1, 1, 1'b1, acc);
      chk("len0_lat", 32'(res_cyc), 32'(acc));
      chk("len0_beats", 32'(hs_cyc.size()), 32'd0);
      send(200, 2, 1, 1'b1, acc);
      chk("len200_lat", 32'(res_cyc), 32'(acc));
      @(negedge clk);
      chk("len200_in_ready", 32'(bus.in_ready), 32'd1);

      // Single character, HAM
      fill_txt(1);
      send(1, 1, 1, 1'b1, acc);
      chk("len1_beats", 32'(hs_cyc.size()), 32'd1);

      // Reset during STREAM at index 2
      fill_txt(6);
      c0 = cls_cnt;
      send(6, 2, 1, 1'b0, acc);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      abort_reset();
      @(negedge clk);
      chk_reset_vals("abort");
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_cls_start", 32'(cls_cnt - c0), 32'd0);
      fill_txt(4);
      send(4, 2, 2, 1'b1, acc);

      // Randomized messages
      for (int t = 0; t < 25; t++) begin
         rmode = $urandom_range(0, 1);
         if ($urandom_range(0, 9) == 0)
            len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(ML + 1, 255);
         else
            len = $urandom_range(1, ML);
         fill_txt(len);
         send(len, $urandom_range(0, 3), $urandom_range(1, 6), 1'b1, acc);
      end
      rmode = 0;

      // Classifier never answers
      fill_txt(4);
`ifdef HDC_SCHED_TIMEOUT_EN
      send(4, 2, 0, 1'b1, acc);
      chk("timeout_lat", 32'(res_cyc - cls_cyc), 32'(TMO + 1));
      n0 = n_res;
      @(posedge clk);
      #1;
      bus.cls_done  = 1'b1;
      bus.cls_label = 2'b01;
      @(posedge clk);
      #1;
      bus.cls_done  = 1'b0;
      repeat (3) @(negedge clk);
      chk("late_done_ignored", 32'(n_res - n0), 32'd0);
      chk("late_done_result", 32'(bus.result), 32'd3);
`else
      send(4, 2, 0, 1'b0, acc);
      hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.busy) hi++;
      end
      chk("wait_blocks", 32'(hi), 32'd100);
      @(posedge clk);
      #1;
      abort_reset();
      @(posedge clk);
      #1 reset = 1'b1;
`endif

      repeat (3) @(negedge clk);
      chk("res_queue_empty", 32'(exp_res.size()), 32'd0);
      chk("beat_queue_empty", 32'(exp_beats.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
